// File: rtl/aes_serial_host.sv
// Host end of the AES core's bit-serial link: launches a transaction with a
// one-cycle Data_Valid pulse, streams plaintext and key MSB-first on two
// serial lines, then deserialises the core's qualified result stream, with
// a watchdog that aborts a stalled response.
module aes_serial_host #(
    parameter int TIMEOUT = 4096
) (
    input  logic         clock,
    input  logic         Reset,
    input  logic         start,
    input  logic [127:0] text_in,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         ser_valid,
    output logic         ser_mem,
    output logic         ser_cipher,
    input  logic         core_busy,
    input  logic         core_valid,
    input  logic         core_data,
    output logic [127:0] result,
    output logic         done,
    output logic         timeout_err
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        SHIFT    = 3'd2,
        WAIT_OUT = 3'd3,
        COLLECT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [127:0]    txt_q, txt_d;
    logic [127:0]    key_q, key_d;
    logic [127:0]    cap_q, cap_d;
    logic [127:0]    result_q, result_d;
    logic [7:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      rx_cnt_q, rx_cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            ser_valid_q, ser_valid_d;
    logic            ser_mem_q, ser_mem_d;
    logic            ser_cipher_q, ser_cipher_d;
    logic            done_q, done_d;
    logic            terr_q, terr_d;
    logic [WD_W-1:0] wd_inc;
    logic [127:0]    cap_next;

    // Busy is status only and the capture MSB falls off the end of the shift.
    logic unused_ok;
    assign unused_ok = ^{core_busy, cap_q[127]};

    // Next-state and registered-output decode. Serial outputs are registered,
    // so each bit is loaded one edge ahead of the cycle it appears in: the
    // LAUNCH edge emits bit 0 and SHIFT emits bits 1..127 while counting.
    always_comb begin
        state_d      = state_q;
        txt_d        = txt_q;
        key_d        = key_q;
        cap_d        = cap_q;
        result_d     = result_q;
        bit_cnt_d    = bit_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        wd_d         = wd_q;
        terr_d       = terr_q;
        ser_valid_d  = 1'b0;
        ser_mem_d    = 1'b0;
        ser_cipher_d = 1'b0;
        done_d       = 1'b0;
        wd_inc       = (wd_q == WD_TERM) ? wd_q : wd_q + 1'b1;
        cap_next     = {cap_q[126:0], core_data};

        case (state_q)
            IDLE: begin
                if (start) begin
                    txt_d       = text_in;
                    key_d       = key_in;
                    cap_d       = '0;
                    terr_d      = 1'b0;
                    bit_cnt_d   = '0;
                    rx_cnt_d    = '0;
                    wd_d        = '0;
                    ser_valid_d = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                ser_mem_d    = txt_q[127];
                ser_cipher_d = key_q[127];
                txt_d        = {txt_q[126:0], 1'b0};
                key_d        = {key_q[126:0], 1'b0};
                state_d      = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_q == 8'd127) begin
                    wd_d    = '0;
                    state_d = WAIT_OUT;
                end else begin
                    ser_mem_d    = txt_q[127];
                    ser_cipher_d = key_q[127];
                    txt_d        = {txt_q[126:0], 1'b0};
                    key_d        = {key_q[126:0], 1'b0};
                    bit_cnt_d    = bit_cnt_q + 8'd1;
                end
            end
            WAIT_OUT, COLLECT: begin
                // A capture takes priority over the watchdog expiring.
                if (core_valid) begin
                    cap_d    = cap_next;
                    rx_cnt_d = rx_cnt_q + 8'd1;
                    wd_d     = '0;
                    if (state_q == WAIT_OUT) begin
                        state_d = COLLECT;
                    end else if (rx_cnt_q == 8'd127) begin
                        result_d = cap_next;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == WD_TERM) begin
                        terr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            state_q      <= IDLE;
            txt_q        <= '0;
            key_q        <= '0;
            cap_q        <= '0;
            result_q     <= '0;
            bit_cnt_q    <= '0;
            rx_cnt_q     <= '0;
            wd_q         <= '0;
            terr_q       <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_mem_q    <= 1'b0;
            ser_cipher_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            txt_q        <= txt_d;
            key_q        <= key_d;
            cap_q        <= cap_d;
            result_q     <= result_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            wd_q         <= wd_d;
            terr_q       <= terr_d;
            ser_valid_q  <= ser_valid_d;
            ser_mem_q    <= ser_mem_d;
            ser_cipher_q <= ser_cipher_d;
            done_q       <= done_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign ser_valid   = ser_valid_q;
    assign ser_mem     = ser_mem_q;
    assign ser_cipher  = ser_cipher_q;
    assign result      = result_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule
